// File: rtl/canvas_cmd_pkg.sv
// Shared constants, command field layout and FSM state type for the canvas
// command decoder.
package canvas_cmd_pkg;

  localparam int FB_COLS_DEF = 512;
  localparam int FB_ROWS_DEF = 256;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_SCROLL_X = 4'h1;
  localparam logic [3:0] OP_SCROLL_Y = 4'h2;
  localparam logic [3:0] OP_PALETTE  = 4'h3;
  localparam logic [3:0] OP_CURSOR   = 4'h4;
  localparam logic [3:0] OP_PIXEL    = 4'h5;
  localparam logic [3:0] OP_FILL     = 4'h6;

  localparam int COL_W     = 9;
  localparam int ROW_W     = 8;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 16;
  localparam int PAL_IDX_W = 8;
  localparam int PAL_COL_W = 12;
  localparam int SX_W      = 10;
  localparam int SY_W      = 9;

  localparam int CUR_COL_LSB = 8;
  localparam int CNT_LSB     = 8;
  localparam int PAL_IDX_LSB = 12;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

endpackage

// File: rtl/canvas_cursor.sv
// Write cursor: load with wrap-on-overflow, advance with column/row wrap
// back to (0,0).
module canvas_cursor
  import canvas_cmd_pkg::*;
#(
  parameter int FB_COLS = FB_COLS_DEF,
  parameter int FB_ROWS = FB_ROWS_DEF
) (
  input  logic             i_cmd_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic [COL_W-1:0] load_col,
  input  logic [ROW_W-1:0] load_row,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  localparam logic [COL_W:0] COLS = (COL_W + 1)'(FB_COLS);
  localparam logic [ROW_W:0] ROWS = (ROW_W + 1)'(FB_ROWS);

  logic [COL_W:0] ld_col_x;
  logic [ROW_W:0] ld_row_x;
  logic [COL_W:0] col_inc;
  logic [ROW_W:0] row_inc;

  assign ld_col_x = {1'b0, load_col};
  assign ld_row_x = {1'b0, load_row};
  assign col_inc  = {1'b0, col} + 1'b1;
  assign row_inc  = {1'b0, row} + 1'b1;

  always_ff @(posedge i_cmd_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= (ld_col_x >= COLS) ? COL_W'(ld_col_x - COLS) : load_col;
      row <= (ld_row_x >= ROWS) ? ROW_W'(ld_row_x - ROWS) : load_row;
    end else if (advance) begin
      if (col_inc == COLS) begin
        col <= '0;
        row <= (row_inc == ROWS) ? '0 : row_inc[ROW_W-1:0];
      end else begin
        col <= col_inc[COL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/canvas_cmd_decoder.sv
// Command-word decoder feeding frame-buffer port A, palette and scroll regs.
// Optional sticky illegal-opcode flag: CANVAS_CMD_ILLEGAL_FLAG_EN.
module canvas_cmd_decoder
  import canvas_cmd_pkg::*;
#(
  parameter int FB_COLS = FB_COLS_DEF,
  parameter int FB_ROWS = FB_ROWS_DEF
) (
  input  logic                 i_cmd_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic [31:0]          i_cmd_data,
  output logic                 o_cmd_ready,
  output logic                 o_fb_we,
  output logic [COL_W-1:0]     o_fb_col,
  output logic [ROW_W-1:0]     o_fb_row,
  output logic [PIX_W-1:0]     o_fb_data,
  output logic                 o_pal_we,
  output logic [PAL_IDX_W-1:0] o_pal_index,
  output logic [PAL_COL_W-1:0] o_pal_color,
  output logic [SX_W-1:0]      o_scroll_x,
  output logic [SY_W-1:0]      o_scroll_y,
  output logic                 o_busy,
  output logic                 o_illegal
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fill_cnt;
  logic [PIX_W-1:0] fill_val;
  logic [3:0]       op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             accept;
  logic             wr;
  logic             ld;
  logic             fill_go;
  logic [PIX_W-1:0] wr_data;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             unused_bits;

  assign op          = i_cmd_data[OP_MSB:OP_LSB];
  assign cmd_cnt     = i_cmd_data[CNT_LSB +: CNT_W];
  assign accept      = i_cmd_valid && (state == IDLE);
  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = (state == FILL);
  assign unused_bits = ^i_cmd_data[27:24];

  always_ff @(posedge i_cmd_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    ld        = 1'b0;
    fill_go   = 1'b0;
    wr_data   = i_cmd_data[PIX_W-1:0];
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_PIXEL:  wr = 1'b1;
            OP_CURSOR: ld = 1'b1;
            OP_FILL: begin
              if (cmd_cnt != '0) begin
                fill_go   = 1'b1;
                wr        = 1'b1;
                state_nxt = FILL;
              end
            end
            default: ;
          endcase
        end
      end
      FILL: begin
        wr_data = fill_val;
        if (fill_cnt == '0) state_nxt = IDLE;
        else                wr        = 1'b1;
      end
    endcase
  end

  canvas_cursor #(
    .FB_COLS (FB_COLS),
    .FB_ROWS (FB_ROWS)
  ) u_cursor (
    .i_cmd_clk (i_cmd_clk),
    .i_rst     (i_rst),
    .load      (ld),
    .load_col  (i_cmd_data[CUR_COL_LSB +: COL_W]),
    .load_row  (i_cmd_data[ROW_W-1:0]),
    .advance   (wr),
    .col       (cur_col),
    .row       (cur_row)
  );

  always_ff @(posedge i_cmd_clk) begin
    if (i_rst) begin
      o_fb_we     <= 1'b0;
      o_fb_col    <= '0;
      o_fb_row    <= '0;
      o_fb_data   <= '0;
      o_pal_we    <= 1'b0;
      o_pal_index <= '0;
      o_pal_color <= '0;
      o_scroll_x  <= '0;
      o_scroll_y  <= '0;
      o_illegal   <= 1'b0;
      fill_cnt    <= '0;
      fill_val    <= '0;
    end else begin
      o_fb_we  <= wr;
      o_pal_we <= 1'b0;
      if (wr) begin
        o_fb_col  <= cur_col;
        o_fb_row  <= cur_row;
        o_fb_data <= wr_data;
      end
      // fill_cnt holds writes still owed after the one issued this cycle
      if (fill_go) begin
        fill_cnt <= cmd_cnt - 1'b1;
        fill_val <= i_cmd_data[PIX_W-1:0];
      end else if (state == FILL && fill_cnt != '0) begin
        fill_cnt <= fill_cnt - 1'b1;
      end
      if (accept) begin
        case (op)
          OP_SCROLL_X: o_scroll_x <= i_cmd_data[SX_W-1:0];
          OP_SCROLL_Y: o_scroll_y <= i_cmd_data[SY_W-1:0];
          OP_PALETTE: begin
            o_pal_we    <= 1'b1;
            o_pal_index <= i_cmd_data[PAL_IDX_LSB +: PAL_IDX_W];
            o_pal_color <= i_cmd_data[PAL_COL_W-1:0];
          end
          default: ;
        endcase
`ifdef CANVAS_CMD_ILLEGAL_FLAG_EN
        if (op > OP_FILL)
          o_illegal <= 1'b1;
        else if (op == OP_NOP && i_cmd_data[0])
          o_illegal <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_canvas_cmd_decoder.sv
// Directed table-driven bench for canvas_cmd_decoder plus fill and
// reset-during-fill sequences.
module tb_canvas_cmd_decoder;

  typedef struct packed {
    logic        fb_we;
    logic [8:0]  col;
    logic [7:0]  row;
    logic [7:0]  fdat;
    logic        pal_we;
    logic [7:0]  pidx;
    logic [11:0] pcol;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic        ready;
    logic        busy;
    logic        ill;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    obs_t        exp;
  } vec_t;

`ifdef CANVAS_CMD_ILLEGAL_FLAG_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] data;
  logic        ready, fb_we, pal_we, busy, ill;
  logic [8:0]  fb_col;
  logic [7:0]  fb_row, fb_data, pal_idx;
  logic [11:0] pal_col;
  logic [9:0]  sx;
  logic [8:0]  sy;

  int checks   = 0;
  int failures = 0;

  canvas_cmd_decoder dut (
    .i_cmd_clk   (clk),
    .i_rst       (rst),
    .i_cmd_valid (valid),
    .i_cmd_data  (data),
    .o_cmd_ready (ready),
    .o_fb_we     (fb_we),
    .o_fb_col    (fb_col),
    .o_fb_row    (fb_row),
    .o_fb_data   (fb_data),
    .o_pal_we    (pal_we),
    .o_pal_index (pal_idx),
    .o_pal_color (pal_col),
    .o_scroll_x  (sx),
    .o_scroll_y  (sy),
    .o_busy      (busy),
    .o_illegal   (ill)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(
    input logic we, input logic [8:0] c, input logic [7:0] r,
    input logic [7:0] d, input logic pw, input logic [7:0] pi,
    input logic [11:0] pc, input logic [9:0] x, input logic [8:0] y,
    input logic rd, input logic bz, input logic il);
    obs_t o;
    o = '{we, c, r, d, pw, pi, pc, x, y, rd, bz, il};
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(fb_we, fb_col, fb_row, fb_data, pal_we, pal_idx, pal_col,
              sx, sy, ready, busy, ill);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = cur();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{32'h1000_03FF, mk(0, 0, 0, 0, 0, 0, 0, 10'h3FF, 0, 1, 0, 0)};
    vecs[1]  = '{32'h2000_01FF, mk(0, 0, 0, 0, 0, 0, 0, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[2]  = '{32'h3002_5F0A, mk(0, 0, 0, 0, 1, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[3]  = '{32'h0000_0000, mk(0, 0, 0, 0, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[4]  = '{32'h4001_FFFF, mk(0, 0, 0, 0, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[5]  = '{32'h5000_00AB, mk(1, 9'h1FF, 8'hFF, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[6]  = '{32'h5000_00AB, mk(1, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[7]  = '{32'h0000_0000, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[8]  = '{32'h9000_1234, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, ILL)};
    vecs[9]  = '{32'h7FFF_FFFF, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, ILL)};
    vecs[10] = '{32'h0000_0000, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, ILL)};
    vecs[11] = '{32'h0000_0001, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[12] = '{32'h4000_0507, mk(0, 0, 0, 8'hAB, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[13] = '{32'h5000_0011, mk(1, 5, 7, 8'h11, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[14] = '{32'h4001_FF03, mk(0, 5, 7, 8'h11, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[15] = '{32'h5000_0022, mk(1, 9'h1FF, 3, 8'h22, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[16] = '{32'h5000_0033, mk(1, 0, 4, 8'h33, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[17] = '{32'h6000_0044, mk(0, 0, 4, 8'h33, 0, 8'h25, 12'hF0A, 10'h3FF, 9'h1FF, 1, 0, 0)};
    vecs[18] = '{32'h1000_0155, mk(0, 0, 4, 8'h33, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 1, 0, 0)};

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Fill of 4 at (10,3); next PIXEL held on valid while busy.
    step(32'h4000_0A03);
    check("fill_cursor", mk(0, 0, 4, 8'h33, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 1, 0, 0));
    @(negedge clk);
    valid = 1'b1;
    data  = 32'h6000_0477;
    @(posedge clk);
    #1;
    data = 32'h5000_0055;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fill4_w%0d", k),
            mk(1, 9'(10 + k), 3, 8'h77, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 0, 1, 0));
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    check("fill4_done", mk(0, 13, 3, 8'h77, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 1, 0, 0));
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("fill4_next_pix", mk(1, 14, 3, 8'h55, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 1, 0, 0));

    // Long fill aborted by reset after five writes.
    @(negedge clk);
    valid = 1'b1;
    data  = 32'h6003_E899;
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill1000_w%0d", k),
            mk(1, 9'(15 + k), 3, 8'h99, 0, 8'h25, 12'hF0A, 10'h155, 9'h1FF, 0, 1, 0));
      if (k < 4) begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("fill_abort_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(32'h5000_00CC);
    check("post_reset_pix", mk(1, 0, 0, 8'hCC, 0, 0, 0, 0, 0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
